// File: rtl/sram_burst_ctrl_if.sv
// System-side bundle for sram_burst_ctrl: burst request, handshake pulses and data streams.
interface sram_burst_ctrl_if #(
    parameter int unsigned D_WIDTH = 16,
    parameter int unsigned A_WIDTH = 16,
    parameter int unsigned LEN_W   = 4
);
    logic               req;
    logic               req_we;
    logic [A_WIDTH-1:0] req_addr;
    logic [LEN_W-1:0]   req_len;
    logic               ack;
    logic               busy;
    logic               done;
    logic [D_WIDTH-1:0] wdata;
    logic               wr_ready;
    logic [D_WIDTH-1:0] rd_data;
    logic               rd_valid;

    modport master (
        output req, req_we, req_addr, req_len, wdata,
        input  ack, busy, done, wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  req, req_we, req_addr, req_len, wdata,
        output ack, busy, done, wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Burst controller for an MT45W8-style pseudo-SRAM: issues the start address, waits out the
// fixed latency, then streams one word per cycle in either direction. Requires LATENCY >= 2.
module sram_burst_ctrl #(
    parameter int unsigned D_WIDTH = 16,
    parameter int unsigned A_WIDTH = 16,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned LATENCY = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    sram_burst_ctrl_if.slave   bus,
    output logic [A_WIDTH-1:0] o_mem_addr,
    output logic               o_mem_adv_l,
    output logic               o_mem_ce_l,
    output logic               o_mem_oe_l,
    output logic               o_mem_we_l,
    output logic               o_mem_ub_l,
    output logic               o_mem_lb_l,
    output logic               o_mem_cre,
    input  logic               i_mem_wait,
    output logic               o_wait_err,
    inout  wire  [D_WIDTH-1:0] io_mem_data
);
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StAddr    = 3'd1;
    localparam logic [2:0] StWait    = 3'd2;
    localparam logic [2:0] StData    = 3'd3;
    localparam logic [2:0] StRecover = 3'd4;

    localparam int unsigned WCW = $clog2(LATENCY + 1);

    logic [2:0]         r_state, w_state_d;
    logic [WCW-1:0]     r_wcnt, w_wcnt_d;
    logic [LEN_W-1:0]   r_word, w_word_d;
    logic [LEN_W-1:0]   r_len;
    logic [A_WIDTH-1:0] r_addr;
    logic               r_we, w_we_d, w_start, w_active;
    logic               r_ce_l, r_adv_l, r_oe_l, r_we_l, r_bsel_l;
    logic               r_ack, r_busy, r_done, r_wr_ready, r_drive, r_rd_valid, r_wait_err;
    logic [D_WIDTH-1:0] r_wdata, r_rd_data;

    always_comb begin
        w_state_d = r_state;
        w_wcnt_d  = r_wcnt;
        w_word_d  = r_word;
        w_start   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.req) begin
                    w_state_d = StAddr;
                    w_start   = 1'b1;
                end
            end
            StAddr: begin
                w_state_d = StWait;
                w_wcnt_d  = WCW'(LATENCY - 2);
            end
            StWait: begin
                if (r_wcnt == '0) begin
                    w_state_d = StData;
                    w_word_d  = '0;
                end else begin
                    w_wcnt_d = r_wcnt - 1'b1;
                end
            end
            StData: begin
                if (r_word == r_len) w_state_d = StRecover;
                else                 w_word_d  = r_word + 1'b1;
            end
            StRecover: w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
        w_we_d   = w_start ? bus.req_we : r_we;
        w_active = (w_state_d == StAddr) || (w_state_d == StWait) || (w_state_d == StData);
    end

    // Pin values are computed from the next state so every output leaves a flop.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_wcnt     <= '0;
            r_word     <= '0;
            r_len      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_ce_l     <= 1'b1;
            r_adv_l    <= 1'b1;
            r_oe_l     <= 1'b1;
            r_we_l     <= 1'b1;
            r_bsel_l   <= 1'b1;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_ready <= 1'b0;
            r_drive    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_wait_err <= 1'b0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
        end else begin
            r_state <= w_state_d;
            r_wcnt  <= w_wcnt_d;
            r_word  <= w_word_d;
            if (w_start) begin
                r_we   <= bus.req_we;
                r_addr <= bus.req_addr;
                r_len  <= bus.req_len;
            end
            r_ce_l     <= ~w_active;
            r_bsel_l   <= ~w_active;
            r_adv_l    <= ~(w_state_d == StAddr);
            r_we_l     <= ~((w_state_d == StAddr) && w_we_d);
            r_oe_l     <= ~(((w_state_d == StWait) || (w_state_d == StData)) && !w_we_d);
            r_ack      <= (w_state_d == StAddr);
            r_busy     <= (w_state_d != StIdle);
            r_done     <= (w_state_d == StRecover);
            // One pulse ahead of each data word: last wait cycle plus words 0..len-1.
            r_wr_ready <= w_we_d && (((w_state_d == StWait) && (w_wcnt_d == '0)) ||
                                     ((w_state_d == StData) && (w_word_d != r_len)));
            r_drive    <= w_we_d && (w_state_d == StData);
            if (r_wr_ready) r_wdata <= bus.wdata;
            r_rd_valid <= (r_state == StData) && !r_we;
            if ((r_state == StData) && !r_we) r_rd_data <= io_mem_data;
            r_wait_err <= r_wait_err | ((r_state == StData) & i_mem_wait);
        end
    end

    assign io_mem_data  = r_drive ? r_wdata : {D_WIDTH{1'bz}};
    assign o_mem_addr   = r_addr;
    assign o_mem_adv_l  = r_adv_l;
    assign o_mem_ce_l   = r_ce_l;
    assign o_mem_oe_l   = r_oe_l;
    assign o_mem_we_l   = r_we_l;
    assign o_mem_ub_l   = r_bsel_l;
    assign o_mem_lb_l   = r_bsel_l;
    assign o_mem_cre    = 1'b0;
    assign o_wait_err   = r_wait_err;
    assign bus.ack      = r_ack;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.wr_ready = r_wr_ready;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: behavioural pseudo-SRAM plus a word-addressed reference memory.
module tb_sram_burst_ctrl;
    localparam int LAT  = 4;
    localparam int MAXC = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_wait;
    logic [15:0] mem_addr;
    logic        mem_adv_l, mem_ce_l, mem_oe_l, mem_we_l, mem_ub_l, mem_lb_l, mem_cre;
    logic        wait_err;
    wire  [15:0] mem_data;

    int checks = 0;
    int errors = 0;

    sram_burst_ctrl_if #(.D_WIDTH(16), .A_WIDTH(16), .LEN_W(4)) bus ();

    sram_burst_ctrl #(.D_WIDTH(16), .A_WIDTH(16), .LEN_W(4), .LATENCY(LAT)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .bus         (bus),
        .o_mem_addr  (mem_addr),
        .o_mem_adv_l (mem_adv_l),
        .o_mem_ce_l  (mem_ce_l),
        .o_mem_oe_l  (mem_oe_l),
        .o_mem_we_l  (mem_we_l),
        .o_mem_ub_l  (mem_ub_l),
        .o_mem_lb_l  (mem_lb_l),
        .o_mem_cre   (mem_cre),
        .i_mem_wait  (mem_wait),
        .o_wait_err  (wait_err),
        .io_mem_data (mem_data)
    );

    always #5 clk = ~clk;

    // Device model: latches the address on adv, data phase starts LAT cycles after it.
    logic [15:0] sram [0:65535];
    logic [15:0] sram_base = 16'h0;
    int          sram_cyc  = 0;
    logic        sram_wr   = 1'b0;
    logic        pre_en    = 1'b0;
    logic [15:0] pre_addr  = 16'h0;
    logic [15:0] pre_data  = 16'h0;
    logic        probe_en  = 1'b0;
    logic [15:0] probe_val = 16'h0;
    logic [15:0] sram_ptr;
    logic        sram_drv;

    assign sram_ptr = sram_base + 16'(sram_cyc - LAT);
    assign sram_drv = !mem_ce_l && !mem_oe_l && !sram_wr && (sram_cyc >= LAT);
    assign mem_data = sram_drv ? sram[sram_ptr] : (probe_en ? probe_val : 16'hzzzz);

    always @(posedge clk) begin
        if (pre_en) sram[pre_addr] <= pre_data;
        if (!mem_ce_l && !mem_adv_l) begin
            sram_base <= mem_addr;
            sram_wr   <= !mem_we_l;
            sram_cyc  <= 1;
        end else if (!mem_ce_l) begin
            if (sram_wr && sram_cyc >= LAT) sram[sram_ptr] <= mem_data;
            sram_cyc <= sram_cyc + 1;
        end else begin
            sram_cyc <= 0;
        end
    end

    logic [15:0] ref_mem [int];
    logic [15:0] rd_q [$];
    logic [15:0] wq [$];
    bit          log_ack [MAXC];
    bit          log_ce  [MAXC];
    bit          log_oe  [MAXC];
    bit          log_rdv [MAXC];
    bit          log_wrr [MAXC];
    int          done_at;

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
        ref_mem[int'(a)] = d;
    endtask

    task automatic probe_bus(output logic [15:0] v0, output logic [15:0] v1);
        probe_en  = 1'b1;
        probe_val = 16'h0000;
        #1 v0 = mem_data;
        probe_val = 16'hFFFF;
        #1 v1 = mem_data;
        probe_en  = 1'b0;
    endtask

    // Issues one burst and logs per-cycle activity, cycle 0 being the address cycle.
    task automatic do_burst(input logic we, input logic [15:0] addr, input logic [3:0] len);
        int tail;
        tail    = 0;
        done_at = -1;
        rd_q.delete();
        for (int i = 0; i < MAXC; i++) begin
            log_ack[i] = 0; log_ce[i] = 0; log_oe[i] = 0; log_rdv[i] = 0; log_wrr[i] = 0;
        end
        @(negedge clk);
        bus.req = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_len = len;
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clk);
            bus.req    = 1'b0;
            log_ack[c] = bus.ack;
            log_ce[c]  = !mem_ce_l;
            log_oe[c]  = !mem_oe_l;
            log_rdv[c] = bus.rd_valid;
            log_wrr[c] = bus.wr_ready;
            if (bus.rd_valid) rd_q.push_back(bus.rd_data);
            if (bus.wr_ready) begin
                if (wq.size() > 0) bus.wdata = wq.pop_front();
                else               bus.wdata = 16'h0;
            end
            if (done_at >= 0) tail++;
            if (bus.done && done_at < 0) done_at = c;
            if (tail == 2) break;
        end
    endtask

    task automatic test_reset();
        logic [15:0] v0, v1;
        reset = 1'b1; mem_wait = 1'b0;
        bus.req = 1'b0; bus.req_we = 1'b0; bus.req_addr = 16'h0; bus.req_len = 4'h0;
        bus.wdata = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_ce_l, mem_adv_l, mem_oe_l, mem_we_l, mem_ub_l, mem_lb_l, mem_cre} !== 7'b1111110)
        begin
            errors++;
            $display("FAIL reset_pins got %b want 1111110",
                     {mem_ce_l, mem_adv_l, mem_oe_l, mem_we_l, mem_ub_l, mem_lb_l, mem_cre});
        end
        checks++;
        if ({bus.ack, bus.busy, bus.done, bus.wr_ready, bus.rd_valid, wait_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_status got %b want 000000",
                     {bus.ack, bus.busy, bus.done, bus.wr_ready, bus.rd_valid, wait_err});
        end
        checks++;
        if (mem_addr !== 16'h0 || bus.rd_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs addr %h rd_data %h want 0 0", mem_addr, bus.rd_data);
        end
        probe_bus(v0, v1);
        checks++;
        if (v0 !== 16'h0000 || v1 !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_bus_released got %h/%h want 0000/ffff", v0, v1);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] v0, v1;
        @(negedge clk);
        bus.req = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'h0040; bus.req_len = 4'd7;
        for (int c = 0; c <= LAT + 1; c++) begin
            @(negedge clk);
            bus.req = 1'b0;
            if (bus.wr_ready) bus.wdata = 16'hA5C3 ^ 16'(c);
        end
        checks++;
        if ({bus.busy, mem_ce_l, bus.wr_ready} !== 3'b101) begin
            errors++;
            $display("FAIL midburst_pre busy/ce_l/wr_ready got %b want 101",
                     {bus.busy, mem_ce_l, bus.wr_ready});
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({mem_ce_l, bus.busy, bus.wr_ready} !== 3'b100) begin
            errors++;
            $display("FAIL midburst_reset ce_l/busy/wr_ready got %b want 100",
                     {mem_ce_l, bus.busy, bus.wr_ready});
        end
        probe_bus(v0, v1);
        checks++;
        if (v0 !== 16'h0000 || v1 !== 16'hFFFF) begin
            errors++;
            $display("FAIL midburst_bus_released got %h/%h want 0000/ffff", v0, v1);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int nack;
        preload(16'h0005, 16'hBEEF);
        do_burst(1'b0, 16'h0005, 4'd0);
        nack = 0;
        for (int c = 0; c < MAXC; c++) nack += int'(log_ack[c]);
        checks++;
        if (!log_ack[0] || nack != 1) begin
            errors++;
            $display("FAIL single_ack at0 %0d count %0d want 1 1", log_ack[0], nack);
        end
        for (int c = 0; c <= LAT + 3; c++) begin
            checks++;
            if (log_oe[c] != (c >= 1 && c <= LAT)) begin
                errors++;
                $display("FAIL single_oe cycle %0d got %0d want %0d", c, log_oe[c],
                         (c >= 1 && c <= LAT));
            end
            checks++;
            if (log_rdv[c] != (c == LAT + 1)) begin
                errors++;
                $display("FAIL single_rdv cycle %0d got %0d want %0d", c, log_rdv[c],
                         (c == LAT + 1));
            end
        end
        checks++;
        if (done_at != LAT + 1) begin
            errors++;
            $display("FAIL single_done got %0d want %0d", done_at, LAT + 1);
        end
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_data got %0d words first %h want 1 beef", rd_q.size(),
                     (rd_q.size() > 0) ? rd_q[0] : 16'h0);
        end
    endtask

    task automatic test_write_readback();
        int nwr, first;
        wq = {16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        do_burst(1'b1, 16'h0010, 4'd3);
        nwr = 0;
        for (int c = 0; c < MAXC; c++) nwr += int'(log_wrr[c]);
        checks++;
        if (nwr != 4 || done_at != LAT + 4) begin
            errors++;
            $display("FAIL wr_pulses got %0d done %0d want 4 %0d", nwr, done_at, LAT + 4);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ref_mem[16 + i] = 16'h00A0 + 16'(i);
            checks++;
            if (sram[16 + i] !== 16'h00A0 + 16'(i)) begin
                errors++;
                $display("FAIL wr_mem addr %0h got %h want %h", 16 + i, sram[16 + i],
                         16'h00A0 + 16'(i));
            end
        end
        do_burst(1'b0, 16'h0010, 4'd3);
        first = -1;
        for (int c = MAXC - 1; c >= 0; c--) if (log_rdv[c]) first = c;
        checks++;
        if (rd_q.size() != 4 || first != LAT + 1 || !log_rdv[LAT + 4]) begin
            errors++;
            $display("FAIL rb_stream words %0d first %0d want 4 %0d", rd_q.size(), first,
                     LAT + 1);
        end
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== 16'h00A0 + 16'(i)) begin
                errors++;
                $display("FAIL rb_data word %0d got %h want %h", i, rd_q[i], 16'h00A0 + 16'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int nack, second;
        bit seen;
        nack = 0; second = -1; seen = 0;
        @(negedge clk);
        bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0010; bus.req_len = 4'd1;
        for (int c = 0; c <= LAT + 1 + 6; c++) begin
            @(negedge clk);
            if (bus.ack) begin
                nack++;
                if (c > 0 && second < 0) second = c;
            end
        end
        bus.req = 1'b0;
        checks++;
        if (nack != 2 || second != LAT + 1 + 3) begin
            errors++;
            $display("FAIL b2b_acks got %0d second %0d want 2 %0d", nack, second, LAT + 4);
        end
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_drain got no done want done");
        end
        @(negedge clk);
    endtask

    task automatic test_long_read();
        int nrdv, nce, first;
        for (int i = 0; i < 16; i++) preload(16'(i), 16'($urandom));
        do_burst(1'b0, 16'h0000, 4'd15);
        nrdv = 0; nce = 0; first = -1;
        for (int c = MAXC - 1; c >= 0; c--) begin
            nrdv += int'(log_rdv[c]);
            nce  += int'(log_ce[c]);
            if (log_rdv[c]) first = c;
        end
        checks++;
        if (nrdv != 16 || first != LAT + 1 || !log_rdv[LAT + 16]) begin
            errors++;
            $display("FAIL long_rdv count %0d first %0d want 16 %0d", nrdv, first, LAT + 1);
        end
        checks++;
        if (nce != LAT + 16 || done_at != LAT + 16) begin
            errors++;
            $display("FAIL long_ce low %0d done %0d want %0d %0d", nce, done_at, LAT + 16,
                     LAT + 16);
        end
        for (int i = 0; i < 16 && i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== ref_mem[i]) begin
                errors++;
                $display("FAIL long_data word %0d got %h want %h", i, rd_q[i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] addr;
        logic [3:0]  len;
        logic [15:0] d;
        int          nwr;
        for (int it = 0; it < 6; it++) begin
            addr = 16'($urandom);
            len  = 4'($urandom_range(0, 15));
            wq.delete();
            for (int i = 0; i <= int'(len); i++) begin
                d = 16'($urandom);
                wq.push_back(d);
                ref_mem[int'(addr + 16'(i))] = d;
            end
            do_burst(1'b1, addr, len);
            nwr = 0;
            for (int c = 0; c < MAXC; c++) nwr += int'(log_wrr[c]);
            checks++;
            if (nwr != int'(len) + 1 || done_at != LAT + 1 + int'(len)) begin
                errors++;
                $display("FAIL rnd_wr it %0d pulses %0d done %0d want %0d %0d", it, nwr,
                         done_at, int'(len) + 1, LAT + 1 + int'(len));
            end
            do_burst(1'b0, addr, len);
            checks++;
            if (rd_q.size() != int'(len) + 1 || done_at != LAT + 1 + int'(len)) begin
                errors++;
                $display("FAIL rnd_rd it %0d words %0d done %0d want %0d %0d", it,
                         rd_q.size(), done_at, int'(len) + 1, LAT + 1 + int'(len));
            end
            for (int i = 0; i < rd_q.size(); i++) begin
                checks++;
                if (rd_q[i] !== ref_mem[int'(addr + 16'(i))]) begin
                    errors++;
                    $display("FAIL rnd_data it %0d word %0d got %h want %h", it, i, rd_q[i],
                             ref_mem[int'(addr + 16'(i))]);
                end
            end
        end
    endtask

    task automatic test_wait_err();
        @(negedge clk);
        bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0000; bus.req_len = 4'd3;
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clk);
            bus.req = 1'b0;
            if (c == 1) mem_wait = 1'b1;
            if (c == 2) begin
                checks++;
                if (wait_err !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_in_latency got %b want 0", wait_err);
                end
                mem_wait = 1'b0;
            end
            if (c == LAT) mem_wait = 1'b1;
            if (c == LAT + 1) begin
                mem_wait = 1'b0;
                checks++;
                if (wait_err !== 1'b1) begin
                    errors++;
                    $display("FAIL wait_in_data got %b want 1", wait_err);
                end
            end
            if (bus.done) break;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wait_err !== 1'b1) begin
            errors++;
            $display("FAIL wait_sticky got %b want 1", wait_err);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (wait_err !== 1'b0) begin
            errors++;
            $display("FAIL wait_cleared got %b want 0", wait_err);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_reset_mid_burst();
        test_single_read();
        test_write_readback();
        test_back_to_back();
        test_long_read();
        test_random();
        test_wait_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end
endmodule
